// File: rtl/fight_pkg.sv
// Shared definitions for both player blocks: action codes, one-hot positions,
// hit reach thresholds and damage values.
package fight_pkg;

  localparam logic [2:0] ACT_KICK   = 3'b000;
  localparam logic [2:0] ACT_PUNCH  = 3'b001;
  localparam logic [2:0] ACT_AWAIT  = 3'b010;
  localparam logic [2:0] ACT_JUMP   = 3'b011;
  localparam logic [2:0] ACT_LEFT1  = 3'b100;
  localparam logic [2:0] ACT_LEFT2  = 3'b101;
  localparam logic [2:0] ACT_RIGHT1 = 3'b110;
  localparam logic [2:0] ACT_RIGHT2 = 3'b111;

  // Player 2 advances 001 -> 010 -> 100; player 1 advances 100 -> 010 -> 001.
  typedef enum logic [2:0] {
    P2_S0 = 3'b001,
    P2_S1 = 3'b010,
    P2_S2 = 3'b100
  } p2_pos_t;

  localparam logic [2:0] P1_S0 = 3'b100;
  localparam logic [2:0] P1_S1 = 3'b010;
  localparam logic [2:0] P1_S2 = 3'b001;

  localparam logic [2:0] KICK_REACH  = 3'd2;
  localparam logic [2:0] PUNCH_REACH = 3'd3;
  localparam logic [1:0] KICK_DMG    = 2'd1;
  localparam logic [1:0] PUNCH_DMG   = 2'd2;

  // Non-one-hot opponent positions are treated as home.
  function automatic logic [1:0] p1_idx(input logic [2:0] s);
    case (s)
      P1_S1:   return 2'd1;
      P1_S2:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/health_tracker.sv
// Health, await counter and knock-out flag for one player; shared by both
// player blocks. Damage always wins over healing in the same cycle.
module health_tracker
  import fight_pkg::*;
#(
  parameter logic [1:0] MAX_HEALTH = 2'b11,
  parameter int         HEAL_WAITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] dmg,
  input  logic       await_act,
  output logic [1:0] health,
  output logic       ko
);

  localparam logic [1:0] HEAL_CNT = 2'(HEAL_WAITS);

  logic [1:0] health_q, health_d;
  logic [1:0] cnt_q, cnt_d, cnt_inc;
  logic       ko_q, ko_d;

  function automatic logic [1:0] sat_sub(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a - b : 2'd0;
  endfunction

  assign cnt_inc = cnt_q + 2'd1;

  always_comb begin
    health_d = health_q;
    cnt_d    = cnt_q;
    ko_d     = ko_q;
    if (!ko_q) begin
      if (dmg != 2'd0) begin
        health_d = sat_sub(health_q, dmg);
        cnt_d    = 2'd0;
        ko_d     = (sat_sub(health_q, dmg) == 2'd0);
      end else if (await_act) begin
        if (cnt_inc == HEAL_CNT) begin
          cnt_d = 2'd0;
          if (health_q < MAX_HEALTH) health_d = health_q + 2'd1;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        cnt_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      health_q <= MAX_HEALTH;
      cnt_q    <= 2'd0;
      ko_q     <= 1'b0;
    end else begin
      health_q <= health_d;
      cnt_q    <= cnt_d;
      ko_q     <= ko_d;
    end
  end

  assign health = health_q;
  assign ko     = ko_q;

endmodule

// File: rtl/second_player.sv
// Player-2 block: position FSM, reach/hit evaluation against player 1, and
// health bookkeeping through health_tracker. Everything freezes once knocked out.
module second_player
  import fight_pkg::*;
#(
  parameter logic [1:0] MAX_HEALTH = 2'b11,
  parameter int         HEAL_WAITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] action2,
  input  logic [2:0] action1,
  input  logic [2:0] state1,
  output logic [2:0] state,
  output logic [1:0] health,
  output logic       ko
);

  p2_pos_t    state_q, state_d;
  logic [1:0] own_idx;
  logic [2:0] reach;
  logic       kick_hit, punch_hit;
  logic [1:0] dmg;

  always_comb begin
    case (state_q)
      P2_S1:   own_idx = 2'd1;
      P2_S2:   own_idx = 2'd2;
      default: own_idx = 2'd0;
    endcase
  end

  // Hits are judged on pre-edge positions; movement applies afterwards.
  assign reach     = {1'b0, own_idx} + {1'b0, p1_idx(state1)};
  assign kick_hit  = (action1 == ACT_KICK)  && (reach >= KICK_REACH) && (action2 != ACT_JUMP);
  assign punch_hit = (action1 == ACT_PUNCH) && (reach >= PUNCH_REACH);
  assign dmg       = kick_hit ? KICK_DMG : (punch_hit ? PUNCH_DMG : 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= P2_S0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!ko) begin
      case (action2)
        ACT_LEFT1, ACT_LEFT2: begin
          case (state_q)
            P2_S0:   state_d = P2_S1;
            default: state_d = P2_S2;
          endcase
        end
        ACT_RIGHT1, ACT_RIGHT2: begin
          case (state_q)
            P2_S2:   state_d = P2_S1;
            default: state_d = P2_S0;
          endcase
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    state = state_q;
  end

  health_tracker #(
    .MAX_HEALTH(MAX_HEALTH),
    .HEAL_WAITS(HEAL_WAITS)
  ) u_health (
    .clk      (clk),
    .rst_n    (rst_n),
    .dmg      (dmg),
    .await_act(action2 == ACT_AWAIT),
    .health   (health),
    .ko       (ko)
  );

endmodule
